prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter width in bits.
REQ-002 SHALL have parameter LUT_DEPTH, default 16, number of entries in the target table (power of two, >= N_PROG).
REQ-003 SHALL have parameter N_PROG, default 4, number of selectable programs (power of two, >= 2).
REQ-004 SHALL have parameter CNT_W, default 16, cycle-counter width.
REQ-005 SHALL have ports, clock and reset first: reset Reset, synchronous, active-high; clock Clk.
REQ-006 Clk  input  1  system clock, posedge only.
REQ-007 Reset  input  1  synchronous active-high reset.
REQ-008 Start  input  1  level request: hold to arm, release to run.
REQ-009 ProgSel  input  log2(N_PROG)  program index, sampled while Start high.
REQ-010 Halt  input  1  decoder done flag for the current instruction.
REQ-011 Stall  input  1  freeze PC this cycle.
REQ-012 BranchEn  input  1  current instruction is a branch or jump.
REQ-013 Taken  input  1  branch condition true.
REQ-014 AbsJump  input  1  1 = absolute target from table, 0 = PC-relative.
REQ-015 TargIdx  input  log2(LUT_DEPTH)  table index for absolute jumps.
REQ-016 RelOff  input  8  signed two's-complement relative offset.
REQ-017 LutWrEn, LutWrIdx, LutWrData  input  1 / log2(LUT_DEPTH) / PC_W  table write port.
REQ-018 ProgCtr  output  PC_W  instruction address.
REQ-019 Run  output  1  high in RUN state.
REQ-020 Ack  output  1  high in DONE state.
REQ-021 CycleCount  output  CNT_W  cycles spent in RUN for the current program.

Function
REQ-022 SHALL implement FSM states IDLE, ARMED, RUN, DONE.
REQ-023 Transitions: IDLE->ARMED on Start; ARMED->RUN on !Start; RUN->DONE on Halt & !Stall; DONE->ARMED on Start; RUN->ARMED on Start (restart).
REQ-024 In ARMED, ProgCtr SHALL load LUT[ProgSel] every cycle; the last ProgSel before Start falls wins.
REQ-025 In RUN with Stall=1, ProgCtr SHALL hold; Halt SHALL be ignored.
REQ-026 In RUN with Stall=0, BranchEn & Taken & AbsJump: ProgCtr <= LUT[TargIdx].
REQ-027 In RUN with Stall=0, BranchEn & Taken & !AbsJump: ProgCtr <= ProgCtr + sign-extended RelOff, modulo 2^PC_W.
REQ-028 Otherwise in RUN, ProgCtr <= ProgCtr + 1, wrapping from all-ones to 0.
REQ-029 Halt & !Stall in RUN SHALL take priority over a branch; ProgCtr holds; DONE is entered next cycle.
REQ-030 In IDLE and DONE, ProgCtr SHALL hold.
REQ-031 A LUT write SHALL take effect next cycle; a same-cycle read of the written index SHALL return the old value.
REQ-032 Start in RUN SHALL take priority over Halt.
REQ-033 Run and Ack SHALL be registered state decodes with no combinational path from inputs.

Reset
REQ-034 Reset SHALL force IDLE, ProgCtr=0, Run=0, Ack=0, CycleCount=0, and all LUT entries=0; Reset overrides all other inputs, including mid-RUN.

Configuration
REQ-035 Macro PROG_SEQUENCER_CYCLE_COUNT_EN defined: CycleCount SHALL clear on entering ARMED, increment each RUN cycle (stalls included), saturate at all-ones, and hold in DONE/IDLE.
REQ-036 Macro not defined: CycleCount SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-037 Reset; write LUT[1]=0x040; Start=1 with ProgSel=1 for 2 cycles, then Start=0 -> ProgCtr=0x040, then Run=1 and ProgCtr 0x041, 0x042 on successive cycles.
REQ-038 RUN at PC=0x050, BranchEn=Taken=1, AbsJump=0, RelOff=-3 (0xFD) -> ProgCtr=0x04D; with RelOff=+5 at PC=0x3FE -> ProgCtr=0x003 (wrap).
REQ-039 RUN, LUT[7]=0x123, BranchEn=Taken=AbsJump=1, TargIdx=7 -> ProgCtr=0x123; same cycle, LUT[7] written 0x200 -> jump still to 0x123.
REQ-040 Halt=1 with Stall=1 -> stay RUN; Halt=1 with Stall=0 -> Ack=1 next cycle, ProgCtr frozen, CycleCount frozen (macro on) at the RUN cycle count, e.g. 10 after 10 RUN cycles.
REQ-041 Macro on, CNT_W=4, run 20 cycles -> CycleCount saturates at 15; macro off -> CycleCount=0 throughout.
REQ-042 Reset asserted mid-RUN with PC=0x080 -> next cycle IDLE, ProgCtr=0, Run=0, Ack=0, LUT entries 0.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: arms on a Start level, selects a program entry point from a
// target table, then steps or branches the PC until Halt. Define
// PROG_SEQUENCER_CYCLE_COUNT_EN to build the saturating RUN-cycle counter.
module prog_sequencer #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16,
  parameter int N_PROG    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [$clog2(N_PROG)-1:0]    ProgSel,
  input  logic                         Halt,
  input  logic                         Stall,
  input  logic                         BranchEn,
  input  logic                         Taken,
  input  logic                         AbsJump,
  input  logic [$clog2(LUT_DEPTH)-1:0] TargIdx,
  input  logic [7:0]                   RelOff,
  input  logic                         LutWrEn,
  input  logic [$clog2(LUT_DEPTH)-1:0] LutWrIdx,
  input  logic [PC_W-1:0]              LutWrData,
  output logic [PC_W-1:0]              ProgCtr,
  output logic                         Run,
  output logic                         Ack,
  output logic [CNT_W-1:0]             CycleCount
);
  localparam int LW = $clog2(LUT_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] sel_tgt, jmp_tgt, rel_ext;

  // Table reads see registered contents, so a same-cycle write is not visible yet.
  assign sel_tgt = lut_q[LW'(ProgSel)];
  assign jmp_tgt = lut_q[TargIdx];
  assign rel_ext = PC_W'($signed(RelOff));

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (Start) state_d = S_ARMED;
      S_ARMED: if (!Start) state_d = S_RUN;
      S_RUN: begin
        if (Start)              state_d = S_ARMED;
        else if (Halt && !Stall) state_d = S_DONE;
      end
      S_DONE:  if (Start) state_d = S_ARMED;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Run = (state_q == S_RUN);
    Ack = (state_q == S_DONE);
  end

  // PC only loads the entry point while Start is held, so the selection seen on
  // the last high cycle is the one that runs.
  always_comb begin
    pc_d = pc_q;
    unique case (state_q)
      S_ARMED: if (Start) pc_d = sel_tgt;
      S_RUN: begin
        if (!Start && !Stall && !Halt) begin
          if (BranchEn && Taken) pc_d = AbsJump ? jmp_tgt : pc_q + rel_ext;
          else                   pc_d = pc_q + PC_W'(1);
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign ProgCtr = pc_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (LutWrEn) begin
      lut_q[LutWrIdx] <= LutWrData;
    end
  end

`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_ARMED && state_q != S_ARMED) cnt_d = '0;
    else if (state_q == S_RUN && cnt_q != '1)     cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign CycleCount = cnt_q;
`else
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: a default instance plus a CNT_W=4 instance
// on the same stimulus; expectations are queued per step and checked after the edge.
module tb_prog_sequencer;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1, Start = 1'b0, Halt = 1'b0, Stall = 1'b0;
  logic       BranchEn = 1'b0, Taken = 1'b0, AbsJump = 1'b0, LutWrEn = 1'b0;
  logic [1:0] ProgSel = '0;
  logic [3:0] TargIdx = '0, LutWrIdx = '0;
  logic [7:0] RelOff = '0;
  logic [9:0] LutWrData = '0;

  logic [9:0]  ProgCtr, ProgCtr4;
  logic        Run, Ack, Run4, Ack4;
  logic [15:0] CycleCount;
  logic [3:0]  CycleCount4;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  typedef struct {
    string       tag;
    logic [9:0]  pc;
    bit          chkpc;
    logic        run;
    logic        ack;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  always #5 Clk = ~Clk;

  prog_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .Stall(Stall), .BranchEn(BranchEn), .Taken(Taken), .AbsJump(AbsJump),
    .TargIdx(TargIdx), .RelOff(RelOff), .LutWrEn(LutWrEn), .LutWrIdx(LutWrIdx),
    .LutWrData(LutWrData), .ProgCtr(ProgCtr), .Run(Run), .Ack(Ack),
    .CycleCount(CycleCount)
  );

  prog_sequencer #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .Stall(Stall), .BranchEn(BranchEn), .Taken(Taken), .AbsJump(AbsJump),
    .TargIdx(TargIdx), .RelOff(RelOff), .LutWrEn(LutWrEn), .LutWrIdx(LutWrIdx),
    .LutWrData(LutWrData), .ProgCtr(ProgCtr4), .Run(Run4), .Ack(Ack4),
    .CycleCount(CycleCount4)
  );

  function automatic logic [15:0] ecnt(input int n);
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [3:0] ecnt4(input int n);
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    return (n > 15) ? 4'hF : 4'(n);
`else
    return 4'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Queue the expected post-edge state, clock once, then drain the queue.
  task automatic step(input string tag, input logic [9:0] pc, input bit chkpc,
                      input logic run, input logic ack);
    exp_t e;
    e.tag = tag; e.pc = pc; e.chkpc = chkpc; e.run = run; e.ack = ack;
    e.cnt = ecnt(ncyc); e.cnt4 = ecnt4(ncyc);
    sb.push_back(e);
    @(posedge Clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chkpc) begin
        chk({e.tag, ".pc"}, 32'(ProgCtr), 32'(e.pc));
        chk({e.tag, ".pc4"}, 32'(ProgCtr4), 32'(e.pc));
      end
      chk({e.tag, ".run"}, 32'({Run4, Run}), 32'({e.run, e.run}));
      chk({e.tag, ".ack"}, 32'({Ack4, Ack}), 32'({e.ack, e.ack}));
      chk({e.tag, ".cnt"}, 32'(CycleCount), 32'(e.cnt));
      chk({e.tag, ".cnt4"}, 32'(CycleCount4), 32'(e.cnt4));
    end
  endtask

  initial begin
    logic [9:0] epc;
    Start = 1'b1; Halt = 1'b1;
    step("reset", 10'h000, 1, 0, 0);

    Reset = 0; Start = 0; Halt = 0;
    LutWrEn = 1; LutWrIdx = 4'd1; LutWrData = 10'h040;
    step("idle_wr1", 10'h000, 1, 0, 0);
    LutWrIdx = 4'd2; LutWrData = 10'h2AA;
    step("idle_wr2", 10'h000, 1, 0, 0);
    LutWrEn = 0; Start = 1; ProgSel = 2'd2;
    step("to_armed", 10'h000, 1, 0, 0);
    step("armed_sel2", 10'h2AA, 1, 0, 0);
    ProgSel = 2'd1;
    step("armed_sel1", 10'h040, 1, 0, 0);
    Start = 0; ProgSel = 2'd2;
    step("to_run", 10'h040, 1, 1, 0);
    ncyc = 1; step("inc1", 10'h041, 1, 1, 0);
    ncyc = 2; step("inc2", 10'h042, 1, 1, 0);
    LutWrEn = 1; LutWrIdx = 4'd3; LutWrData = 10'h050;
    ncyc = 3; step("inc3", 10'h043, 1, 1, 0);
    LutWrEn = 0; BranchEn = 1; Taken = 1; AbsJump = 1; TargIdx = 4'd3;
    ncyc = 4; step("abs_050", 10'h050, 1, 1, 0);
    AbsJump = 0; RelOff = 8'hFD;
    ncyc = 5; step("rel_m3", 10'h04D, 1, 1, 0);
    Taken = 0;
    ncyc = 6; step("not_taken", 10'h04E, 1, 1, 0);
    Taken = 1; Halt = 1; Stall = 1;
    LutWrEn = 1; LutWrIdx = 4'd4; LutWrData = 10'h3FE;
    ncyc = 7; step("stall_halt", 10'h04E, 1, 1, 0);
    Halt = 0; Stall = 0; LutWrEn = 0; AbsJump = 1; TargIdx = 4'd4;
    ncyc = 8; step("abs_3fe", 10'h3FE, 1, 1, 0);
    AbsJump = 0; RelOff = 8'h05;
    LutWrEn = 1; LutWrIdx = 4'd7; LutWrData = 10'h123;
    ncyc = 9; step("rel_wrap", 10'h003, 1, 1, 0);
    AbsJump = 1; TargIdx = 4'd7; LutWrData = 10'h200;
    ncyc = 10; step("abs_old_val", 10'h123, 1, 1, 0);
    LutWrEn = 0;
    ncyc = 11; step("abs_new_val", 10'h200, 1, 1, 0);
    TargIdx = 4'd4;
    ncyc = 12; step("abs_3fe_b", 10'h3FE, 1, 1, 0);
    BranchEn = 0;
    ncyc = 13; step("inc_3ff", 10'h3FF, 1, 1, 0);
    ncyc = 14; step("inc_wrap", 10'h000, 1, 1, 0);
    Halt = 1; BranchEn = 1; Taken = 1; AbsJump = 1; TargIdx = 4'd7;
    ncyc = 15; step("halt_over_br", 10'h000, 1, 0, 1);
    Halt = 0; BranchEn = 0;
    step("done_hold", 10'h000, 1, 0, 1);

    Start = 1; ProgSel = 2'd1;
    ncyc = 0; step("done_to_arm", 10'h000, 1, 0, 0);
    step("arm_load", 10'h040, 1, 0, 0);
    Start = 0;
    step("run2", 10'h040, 1, 1, 0);
    Start = 1; Halt = 1;
    step("restart_prio", 10'h000, 0, 0, 0);
    Halt = 0;
    step("rearm_load", 10'h040, 1, 0, 0);
    Start = 0; LutWrEn = 1; LutWrIdx = 4'd5; LutWrData = 10'h080;
    step("run3", 10'h040, 1, 1, 0);
    LutWrEn = 0;

    epc = 10'h040;
    for (int i = 0; i < 20; i++) begin
      Stall = ((i % 3) == 2);
      if (!Stall) epc = epc + 10'd1;
      ncyc++;
      step($sformatf("long%0d", i), epc, 1, 1, 0);
    end
    Stall = 0; BranchEn = 1; Taken = 1; AbsJump = 1; TargIdx = 4'd5;
    ncyc++; step("abs_080", 10'h080, 1, 1, 0);

    BranchEn = 0; Reset = 1; Start = 1;
    ncyc = 0; step("reset_mid_run", 10'h000, 1, 0, 0);
    Reset = 0; Start = 0;
    step("post_reset_idle", 10'h000, 1, 0, 0);
    Start = 1; ProgSel = 2'd1;
    step("arm_after_rst", 10'h000, 1, 0, 0);
    step("lut_cleared", 10'h000, 1, 0, 0);
    Start = 0;
    step("run_after_rst", 10'h000, 1, 1, 0);
    ncyc = 1; step("inc_after_rst", 10'h001, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
